bram_be_port_arbiter: RTL and testbench
=======================================

// Module: bram_be_port_arbiter
// PURPOSE
//  Shares one byte-enabled port of a dual-ported BRAM (write-first, WE_WIDTH byte lanes) between two requesters, A and B.
//  - Arbitration is round-robin.
//  - Read data returns in order, per requester, through credit-protected response FIFOs.
//  - Sits between two client engines and port A or B of the BRAM2BE-style primitive.
// PARAMETERS
//  PIPELINED   0   1 = BRAM output register present; adds 1 cycle of read latency
//  ADDR_WIDTH  10  BRAM address width
//  DATA_WIDTH  32  data width; equals CHUNKSIZE*WE_WIDTH
//  WE_WIDTH    4   byte-enable lanes
//  RSP_DEPTH   2   entries per response FIFO (>=1); also the initial credit count
// PORTS
//  CLK         in   1           clock; all logic is rising-edge
//  RST_N       in   1           asynchronous, active-low reset
//  REQA_VALID  in   1           requester A presents a request
//  REQA_READY  out  1           request A accepted this cycle
//  REQA_WE     in   WE_WIDTH    byte enables; all-zero = read
//  REQA_ADDR   in   ADDR_WIDTH  request address
//  REQA_DATA   in   DATA_WIDTH  write data
//  RSPA_VALID  out  1           read response available to A
//  RSPA_READY  in   1           A pops the response
//  RSPA_DATA   out  DATA_WIDTH  read data
//  REQB_*/RSPB_*     --         identical set for requester B
//  BRAM_EN     out  1           to BRAM EN
//  BRAM_WE     out  WE_WIDTH    to BRAM WE
//  BRAM_ADDR   out  ADDR_WIDTH  to BRAM ADDR
//  BRAM_DI     out  DATA_WIDTH  to BRAM DI
//  BRAM_DO     in   DATA_WIDTH  from BRAM DO
// BEHAVIOUR
//  - Reset (RST_N=0, async):
//    - REQx_READY, RSPx_VALID, BRAM_EN, BRAM_WE = 0; BRAM_ADDR, BRAM_DI = 0.
//    - Both FIFOs empty; both credits = RSP_DEPTH; round-robin pointer favours A.
//    - In-flight reads are discarded. A reset mid-operation loses them silently.
//  - Eligibility: elig_x = REQx_VALID && (|REQx_WE || credit_x != 0). Writes need no credit.
//  - Grant (combinational, at most one per cycle):
//    - Only one requester eligible -> it wins.
//    - Both eligible -> the pointer's favourite wins.
//    - REQx_READY = grant_x. READY may depend on VALID.
//  - Pointer update: after a grant to x, the pointer favours the other requester. No grant -> pointer unchanged.
//  - Issue: the accepted request is registered.
//    - Next cycle: BRAM_EN=1, BRAM_WE/ADDR/DI = request fields.
//    - Otherwise BRAM_EN=0, BRAM_WE=0.
//    - Throughput: 1 request per cycle, back to back.
//  - Read tracking: shift register of depth 1+PIPELINED, holding {valid, id}.
//    - Entry emerges the cycle BRAM_DO is valid; BRAM_DO is then pushed into FIFO[id].
//  - Latency: read accepted in cycle T -> RSPx_VALID in cycle T+3+PIPELINED (empty FIFO).
//  - Credit_x (clog2(RSP_DEPTH+1) bits):
//    - Decremented on read accept, incremented on RSPx pop. Both in the same cycle -> unchanged.
//    - Never exceeds RSP_DEPTH, never underflows. The FIFO therefore never overflows.
//  - Ordering:
//    - Single port, so issue order equals BRAM order.
//    - A read issued after a write to the same address returns the new bytes.
//    - Only lanes with WE=1 are modified.
//  - FIFO: RSPx_VALID = !empty. Pop when VALID && READY.
//    - Push and pop together when full: legal; count unchanged.
//    - Push into empty FIFO: visible the next cycle (no bypass).
//  - VALID held with READY=0 is allowed. Fields must stay stable until accepted (requester rule).
// CONFIGURATION
//  BRAM_ARB_WRACK_EN defined:
//    - Writes also consume a credit and push a write-ack entry (data = 0) into FIFO[id].
//    - The ack arrives at the same latency as a read.
//    - elig_x requires credit_x != 0 for all requests.
//  BRAM_ARB_WRACK_EN undefined: writes produce no response and need no credit.
// TESTING
//  1. Single read: B writes WE=4'hF, addr 5, 32'hDEADBEEF; then A reads addr 5
//     -> RSPA_DATA=32'hDEADBEEF exactly 3+PIPELINED cycles after accept.
//  2. Byte lanes: write 32'h11223344 with WE=4'hF, then 32'hAABBCCDD with WE=4'b0101; read
//     -> 32'h11BB33DD.
//  3. Contention: A and B VALID every cycle for 8 cycles -> grants alternate A,B,A,B...
//     - After reset, first grant goes to A. BRAM_EN high 8 consecutive cycles.
//  4. Credits: RSP_DEPTH=2, RSPA_READY=0, A issues 4 reads
//     - Only 2 accepted. REQA_READY stays 0 while B keeps being granted.
//     - Raising RSPA_READY releases the rest, in order.
//  5. Reset mid-flight: assert RST_N=0 one cycle after a read accept
//     -> no RSPx_VALID ever appears; credits=RSP_DEPTH afterwards.
//  6. BRAM_ARB_WRACK_EN: 1 write from A -> one RSPA_VALID with data 0 at T+3+PIPELINED.
//     - Undefined: no response.

Source files
------------

// File: rtl/bram_be_port_arbiter.sv
// bram_be_port_arbiter: shares one byte-enabled, write-first BRAM port between
// requesters A and B. Arbitration is round-robin. Read data returns in order per
// requester through response FIFOs. Each FIFO is guarded by a credit counter, so it
// never overflows.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqa_* / reqb_*             request handshake (we all-zero = read), addr, data
//   rspa_* / rspb_*             response handshake and read data
//   bram_en/we/addr/di, bram_do connection to one BRAM port
// Parameter PIPELINED=1 accounts for a BRAM output register (+1 cycle read latency).
// Optional feature macro BRAM_ARB_WRACK_EN: writes also consume a credit and return
// a zero-data acknowledge with the same latency as a read.
module bram_be_port_arbiter #(
  parameter int unsigned PIPELINED  = 0,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WE_WIDTH   = 4,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reqa_valid,
  output logic                  reqa_ready,
  input  logic [WE_WIDTH-1:0]   reqa_we,
  input  logic [ADDR_WIDTH-1:0] reqa_addr,
  input  logic [DATA_WIDTH-1:0] reqa_data,
  output logic                  rspa_valid,
  input  logic                  rspa_ready,
  output logic [DATA_WIDTH-1:0] rspa_data,
  input  logic                  reqb_valid,
  output logic                  reqb_ready,
  input  logic [WE_WIDTH-1:0]   reqb_we,
  input  logic [ADDR_WIDTH-1:0] reqb_addr,
  input  logic [DATA_WIDTH-1:0] reqb_data,
  output logic                  rspb_valid,
  input  logic                  rspb_ready,
  output logic [DATA_WIDTH-1:0] rspb_data,
  output logic                  bram_en,
  output logic [WE_WIDTH-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned TD = 1 + PIPELINED;

  // Index 0 = requester A, index 1 = requester B
  logic [1:0]            req_valid;
  logic [WE_WIDTH-1:0]   req_we   [2];
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] req_data [2];
  logic [1:0]            rsp_ready;
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data [2];

  assign req_valid   = {reqb_valid, reqa_valid};
  assign req_we[0]   = reqa_we;
  assign req_we[1]   = reqb_we;
  assign req_addr[0] = reqa_addr;
  assign req_addr[1] = reqb_addr;
  assign req_data[0] = reqa_data;
  assign req_data[1] = reqb_data;
  assign rsp_ready   = {rspb_ready, rspa_ready};

  logic [1:0] has_credit;
  logic [1:0] needs_credit;
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] consume;
  logic [1:0] pop;
  logic [1:0] push;
  logic       gid;
  logic       ptr_b;

  // Eligibility and round-robin grant; ptr_b=1 means B is favoured on a tie
  always_comb begin
    needs_credit = '0;
    elig         = '0;
    grant        = '0;
    for (int i = 0; i < 2; i++) begin
`ifdef BRAM_ARB_WRACK_EN
      needs_credit[i] = 1'b1;
`else
      needs_credit[i] = ~|req_we[i];
`endif
      elig[i] = req_valid[i] && (!needs_credit[i] || has_credit[i]);
    end
    if (&elig) grant = ptr_b ? 2'b10 : 2'b01;
    else       grant = elig;
  end

  assign gid        = grant[1];
  assign consume    = grant & needs_credit;
  assign reqa_ready = grant[0];
  assign reqb_ready = grant[1];

  // Round-robin pointer: after a grant the other requester is favoured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr_b <= 1'b0;
    else if (|grant) ptr_b <= grant[0];
  end

  // Issue stage: accepted request drives the BRAM port in the following cycle
  logic iss_v, iss_id, iss_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_en   <= 1'b0;
      bram_we   <= '0;
      bram_addr <= '0;
      bram_di   <= '0;
      iss_v     <= 1'b0;
      iss_id    <= 1'b0;
      iss_wr    <= 1'b0;
    end else begin
      bram_en <= |grant;
      bram_we <= (|grant) ? req_we[gid] : '0;
      iss_v   <= |consume;
      iss_id  <= gid;
      iss_wr  <= |req_we[gid];
      if (|grant) begin
        bram_addr <= req_addr[gid];
        bram_di   <= req_data[gid];
      end
    end
  end

  // Response tracking: the last stage lines up with valid bram_do
  logic [TD-1:0]         trk_v, trk_id, trk_wr;
  logic [DATA_WIDTH-1:0] push_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_v  <= '0;
      trk_id <= '0;
      trk_wr <= '0;
    end else begin
      trk_v[0]  <= iss_v;
      trk_id[0] <= iss_id;
      trk_wr[0] <= iss_wr;
      for (int k = 1; k < TD; k++) begin
        trk_v[k]  <= trk_v[k-1];
        trk_id[k] <= trk_id[k-1];
        trk_wr[k] <= trk_wr[k-1];
      end
    end
  end

  assign push      = {trk_v[TD-1] & trk_id[TD-1], trk_v[TD-1] & ~trk_id[TD-1]};
  assign push_data = trk_wr[TD-1] ? '0 : bram_do;

  // Per-requester response FIFO plus credit counter
  for (genvar g = 0; g < 2; g++) begin : g_rsp
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]         wp, rp;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         credit;

    assign rsp_valid[g]  = (cnt != '0);
    assign rsp_data[g]   = mem[rp];
    assign pop[g]        = rsp_valid[g] & rsp_ready[g];
    assign has_credit[g] = (credit != '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp     <= '0;
        rp     <= '0;
        cnt    <= '0;
        credit <= CW'(RSP_DEPTH);
      end else begin
        if (push[g]) wp <= (wp == PW'(RSP_DEPTH - 1)) ? '0 : wp + PW'(1);
        if (pop[g])  rp <= (rp == PW'(RSP_DEPTH - 1)) ? '0 : rp + PW'(1);
        case ({push[g], pop[g]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
        case ({consume[g], pop[g]})
          2'b10:   credit <= credit - CW'(1);
          2'b01:   credit <= credit + CW'(1);
          default: credit <= credit;
        endcase
      end
    end

    // Data storage needs no reset; occupancy is tracked by cnt
    always_ff @(posedge clk) begin
      if (push[g]) mem[wp] <= push_data;
    end
  end

  assign rspa_valid = rsp_valid[0];
  assign rspb_valid = rsp_valid[1];
  assign rspa_data  = rsp_data[0];
  assign rspb_data  = rsp_data[1];

endmodule

// File: tb/tb_bram_be_port_arbiter.sv
// Testbench for bram_be_port_arbiter. A behavioural BRAM is attached to the port,
// and a reference model checks every cycle: a word memory, per-requester queues of
// owed responses with due times, and a favourite flag.
module tb_bram_be_port_arbiter;
  localparam int unsigned P     = 0;
  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned WW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int          LAT   = 3 + P;
`ifdef BRAM_ARB_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reqa_valid, reqa_ready, rspa_valid, rspa_ready;
  logic          reqb_valid, reqb_ready, rspb_valid, rspb_ready;
  logic [WW-1:0] reqa_we, reqb_we, bram_we;
  logic [AW-1:0] reqa_addr, reqb_addr, bram_addr;
  logic [DW-1:0] reqa_data, reqb_data, rspa_data, rspb_data, bram_di, bram_do;
  logic          bram_en;

  always #5 clk = ~clk;

  bram_be_port_arbiter #(
    .PIPELINED(P), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .reqa_valid(reqa_valid), .reqa_ready(reqa_ready), .reqa_we(reqa_we),
    .reqa_addr(reqa_addr), .reqa_data(reqa_data),
    .rspa_valid(rspa_valid), .rspa_ready(rspa_ready), .rspa_data(rspa_data),
    .reqb_valid(reqb_valid), .reqb_ready(reqb_ready), .reqb_we(reqb_we),
    .reqb_addr(reqb_addr), .reqb_data(reqb_data),
    .rspb_valid(rspb_valid), .rspb_ready(rspb_ready), .rspb_data(rspb_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_di(bram_di), .bram_do(bram_do)
  );

  // Behavioural write-first byte-enabled BRAM
  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] di,
                                          logic [WW-1:0] we);
    logic [DW-1:0] w;
    w = old;
    for (int l = 0; l < WW; l++) if (we[l]) w[8*l +: 8] = di[8*l +: 8];
    return w;
  endfunction

  logic [DW-1:0] bmem [1 << AW];
  logic [DW-1:0] do_r, do_p;
  always @(posedge clk) begin
    if (bram_en) begin
      bmem[bram_addr] <= merge(bmem[bram_addr], bram_di, bram_we);
      do_r            <= merge(bmem[bram_addr], bram_di, bram_we);
    end
    do_p <= do_r;
  end
  assign bram_do = (P != 0) ? do_p : do_r;

  // Reference model state
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } rsp_t;
  rsp_t          qa[$], qb[$];
  logic [DW-1:0] rmem [8];
  int            out_a, out_b, cyc, last_cyc;
  bit            fav_b, p_en;
  logic [WW-1:0] p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_di;

  // Stimulus and per-cycle observations
  bit            av, bv, ardy, brdy;
  logic [WW-1:0] awe, bwe;
  logic [AW-1:0] aaddr, baddr;
  logic [DW-1:0] adata, bdata, last_pa;
  bit            last_ga, last_gb, seen_va, obs_en;
  int            n_pop_a;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit owes(logic [WW-1:0] we);
    return WRACK || (we == '0);
  endfunction

  task automatic model_reset();
    qa.delete();
    qb.delete();
    out_a = 0;
    out_b = 0;
    fav_b = 1'b0;
    p_en  = 1'b0;
  endtask

  // Apply an accepted request to the model in acceptance (= BRAM) order
  task automatic accept(input bit isb, input logic [WW-1:0] we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data);
    rsp_t r;
    if (we != '0) rmem[addr[2:0]] = merge(rmem[addr[2:0]], data, we);
    r.t = cyc + LAT;
    r.d = (we != '0) ? '0 : rmem[addr[2:0]];
    if (owes(we)) begin
      if (isb) begin qb.push_back(r); out_b++; end
      else     begin qa.push_back(r); out_a++; end
    end
  endtask

  // One clock: drive after the edge, check and update the model at the falling edge
  task automatic tick();
    bit ea, eb, ga, gb, eva, evb;
    @(posedge clk);
    #1;
    reqa_valid = av; reqa_we = awe; reqa_addr = aaddr; reqa_data = adata; rspa_ready = ardy;
    reqb_valid = bv; reqb_we = bwe; reqb_addr = baddr; reqb_data = bdata; rspb_ready = brdy;
    @(negedge clk);
    ea = av && (!owes(awe) || out_a < DEPTH);
    eb = bv && (!owes(bwe) || out_b < DEPTH);
    ga = ea && (!eb || !fav_b);
    gb = eb && !ga;
    chk("reqa_ready", 64'(reqa_ready), 64'(ga));
    chk("reqb_ready", 64'(reqb_ready), 64'(gb));
    chk("bram_en", 64'(bram_en), 64'(p_en));
    chk("bram_we", 64'(bram_we), p_en ? 64'(p_we) : 64'd0);
    if (p_en) begin
      chk("bram_addr", 64'(bram_addr), 64'(p_addr));
      chk("bram_di", 64'(bram_di), 64'(p_di));
    end
    eva = (qa.size() != 0) && (qa[0].t <= cyc);
    evb = (qb.size() != 0) && (qb[0].t <= cyc);
    chk("rspa_valid", 64'(rspa_valid), 64'(eva));
    chk("rspb_valid", 64'(rspb_valid), 64'(evb));
    if (eva && ardy) begin
      chk("rspa_data", 64'(rspa_data), 64'(qa[0].d));
      last_pa = rspa_data;
      n_pop_a++;
      void'(qa.pop_front());
      out_a--;
    end
    if (evb && brdy) begin
      chk("rspb_data", 64'(rspb_data), 64'(qb[0].d));
      void'(qb.pop_front());
      out_b--;
    end
    seen_va = rspa_valid;
    obs_en  = bram_en;
    p_en    = ga || gb;
    if (ga) begin
      p_we = awe; p_addr = aaddr; p_di = adata;
      accept(1'b0, awe, aaddr, adata);
      fav_b = 1'b1;
      av    = 1'b0;
    end else if (gb) begin
      p_we = bwe; p_addr = baddr; p_di = bdata;
      accept(1'b1, bwe, baddr, bdata);
      fav_b = 1'b0;
      bv    = 1'b0;
    end else begin
      p_we = '0;
    end
    last_ga  = ga;
    last_gb  = gb;
    last_cyc = cyc;
    cyc++;
  endtask

  task automatic reset_pulse(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    av = 1'b0; bv = 1'b0;
    reqa_valid = 1'b0; reqb_valid = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    chk("rst_bram_we", 64'(bram_we), 64'd0);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    chk("rst_bram_di", 64'(bram_di), 64'd0);
    chk("rst_rspa_valid", 64'(rspa_valid), 64'd0);
    chk("rst_rspb_valid", 64'(rspb_valid), 64'd0);
    chk("rst_reqa_ready", 64'(reqa_ready), 64'd0);
    chk("rst_reqb_ready", 64'(reqb_ready), 64'd0);
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_a(input logic [WW-1:0] we, input int addr, input logic [DW-1:0] d);
    av = 1'b1; awe = we; aaddr = AW'(addr); adata = d;
  endtask

  task automatic set_b(input logic [WW-1:0] we, input int addr, input logic [DW-1:0] d);
    bv = 1'b1; bwe = we; baddr = AW'(addr); bdata = d;
  endtask

  initial begin
    int t0, ga_n, gb_n, en_n, np, na, cnt;
    logic [7:0] gseq;
    rst_n = 1'b0;
    av = 1'b0; bv = 1'b0; ardy = 1'b1; brdy = 1'b1;
    awe = '0; bwe = '0; aaddr = '0; baddr = '0; adata = '0; bdata = '0;
    reqa_valid = 1'b0; reqb_valid = 1'b0; rspa_ready = 1'b1; rspb_ready = 1'b1;
    reqa_we = '0; reqb_we = '0; reqa_addr = '0; reqb_addr = '0;
    reqa_data = '0; reqb_data = '0;
    cyc = 0; n_pop_a = 0; last_pa = '0;
    for (int i = 0; i < 8; i++) rmem[i] = '0;
    model_reset();
    reset_pulse(2);

    // Contention: both valid every cycle; writes also initialise words 0..7
    gseq = '0; en_n = 0; na = 0; cnt = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) begin
        if (!av) begin set_a(4'hF, (2 * na) % 8, DW'($urandom())); na++; end
        if (!bv) begin set_b(4'hF, (2 * cnt + 1) % 8, DW'($urandom())); cnt++; end
      end
      tick();
      if (k < 8) gseq[k] = last_gb;
      if (k > 0) en_n += int'(obs_en);
    end
    chk("contend_grant_seq", 64'(gseq), 64'h00AA);
    chk("contend_bram_en_run", 64'(en_n), 64'd8);

    // Single read after a write from the other requester
    set_b(4'hF, 5, 32'hDEADBEEF);
    tick();
    set_a('0, 5, '0);
    tick();
    chk("single_rd_accept", 64'(last_ga), 64'd1);
    t0 = last_cyc;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (seen_va) break;
    end
    chk("single_rd_latency", 64'(last_cyc - t0), 64'(LAT));
    chk("single_rd_data", 64'(last_pa), 64'hDEADBEEF);
    repeat (3) tick();

    // Byte lanes
    set_a(4'hF, 2, 32'h11223344);
    tick();
    set_a(4'b0101, 2, 32'hAABBCCDD);
    tick();
    set_a('0, 2, '0);
    tick();
    np = n_pop_a;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (n_pop_a != np) break;
    end
    chk("bytelane_pops", 64'(n_pop_a - np), 64'd1);
    chk("bytelane_data", 64'(last_pa), 64'h11BB33DD);
    repeat (3) tick();

    // Credits: A blocked after DEPTH reads while responses are not popped
    ardy = 1'b0; ga_n = 0; na = 0; np = n_pop_a;
    for (int k = 0; k < 8; k++) begin
      if (!av && na < 4) begin set_a('0, na, '0); na++; end
      if (!bv) set_b(4'hF, 4 + (k % 4), DW'($urandom()));
      tick();
      ga_n += int'(last_ga);
    end
    chk("credit_a_accepts", 64'(ga_n), 64'(DEPTH));
    ardy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!av && na < 4) begin set_a('0, na, '0); na++; end
      tick();
      if (n_pop_a - np >= 4 && !av && !bv) break;
    end
    chk("credit_a_pops", 64'(n_pop_a - np), 64'd4);
    repeat (4) tick();

    // Reset one cycle after a read accept discards the read
    set_a('0, 5, '0);
    tick();
    chk("midflight_accept", 64'(last_ga), 64'd1);
    reset_pulse(1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cnt += int'(seen_va);
    end
    chk("midflight_no_rsp", 64'(cnt), 64'd0);
    ardy = 1'b0; ga_n = 0; na = 0;
    for (int k = 0; k < 6; k++) begin
      if (!av && na < 3) begin set_a('0, na, '0); na++; end
      tick();
      ga_n += int'(last_ga);
    end
    chk("midflight_credits", 64'(ga_n), 64'(DEPTH));
    ardy = 1'b1;
    for (int k = 0; k < 20; k++) tick();

    // Write acknowledge (present only with the optional feature)
    set_a(4'hF, 6, 32'h0BADF00D);
    tick();
    chk("wrack_accept", 64'(last_ga), 64'd1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cnt += int'(seen_va);
    end
    chk("wrack_rsp_count", 64'(cnt), 64'(WRACK));

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      if (!av && $urandom_range(0, 1) != 0)
        set_a(($urandom_range(0, 1) != 0) ? WW'(0) : WW'($urandom_range(1, 15)),
              int'($urandom_range(0, 7)), DW'($urandom()));
      if (!bv && $urandom_range(0, 1) != 0)
        set_b(($urandom_range(0, 1) != 0) ? WW'(0) : WW'($urandom_range(1, 15)),
              int'($urandom_range(0, 7)), DW'($urandom()));
      ardy = ($urandom_range(0, 3) != 0);
      brdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    ardy = 1'b1; brdy = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("drain_a_empty", 64'(qa.size()), 64'd0);
    chk("drain_b_empty", 64'(qb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
